// File: rtl/rgb_mixer_pkg.sv
// Shared widths, colour-level mapping and the reset palette image for the layer mixer.
package rgb_mixer_pkg;

  localparam int unsigned RGB_W = 8;
  localparam int unsigned R_W   = 3;
  localparam int unsigned G_W   = 3;
  localparam int unsigned B_W   = 2;

  // Entries 1..NUM_DEFAULT form a 3x3x3 colour cube; everything above resets to white.
  localparam int unsigned NUM_DEFAULT = 27;
  localparam int unsigned NUM_LEVELS  = 3;

  localparam logic [R_W-1:0] RG_LEVEL_0 = 3'd0;
  localparam logic [R_W-1:0] RG_LEVEL_1 = 3'd3;
  localparam logic [R_W-1:0] RG_LEVEL_2 = 3'd7;
  localparam logic [B_W-1:0] B_LEVEL_0  = 2'd0;
  localparam logic [B_W-1:0] B_LEVEL_1  = 2'd1;
  localparam logic [B_W-1:0] B_LEVEL_2  = 2'd3;

  localparam logic [RGB_W-1:0] RGB_BLACK = 8'h00;
  localparam logic [RGB_W-1:0] RGB_WHITE = 8'hFF;

  typedef logic [RGB_W-1:0] rgb_t;

  function automatic logic [R_W-1:0] rg_level(input int unsigned lvl);
    case (lvl)
      0:       return RG_LEVEL_0;
      1:       return RG_LEVEL_1;
      default: return RG_LEVEL_2;
    endcase
  endfunction

  function automatic logic [B_W-1:0] b_level(input int unsigned lvl);
    case (lvl)
      0:       return B_LEVEL_0;
      1:       return B_LEVEL_1;
      default: return B_LEVEL_2;
    endcase
  endfunction

  function automatic rgb_t default_palette(input int unsigned idx);
    int unsigned d;
    if (idx == 0) begin
      return RGB_BLACK;
    end
    if (idx > NUM_DEFAULT) begin
      return RGB_WHITE;
    end
    d = idx - 1;
    return {rg_level(d % NUM_LEVELS),
            rg_level((d / NUM_LEVELS) % NUM_LEVELS),
            b_level(d / (NUM_LEVELS * NUM_LEVELS))};
  endfunction

endpackage

// File: rtl/rgb_palette.sv
// Run-time writable colour palette with reset image, write-protected black entry 0 and a
// registered read port that can be forced to black.
module rgb_palette
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [CODE_W-1:0] waddr_i,
  input  rgb_t              wdata_i,
  input  logic [CODE_W-1:0] raddr_i,
  input  logic              rmask_i,
  output rgb_t              rdata_o
);

  localparam int unsigned Depth = 2 ** CODE_W;

  rgb_t mem_q [Depth];
  rgb_t rdata_q;

  // Read and write share the edge, so a lookup coinciding with a write sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= default_palette(i);
      end
      rdata_q <= RGB_BLACK;
    end else begin
      if (we_i && (waddr_i != '0)) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= rmask_i ? RGB_BLACK : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rgb_layer_mixer.sv
// Two-stage pixel compositor: priority-merges palette-coded layers, looks the winner up in
// the palette and delays the syncs so they stay aligned with the colour outputs.
module rgb_layer_mixer
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned CODE_W     = 5,
  parameter logic        SYNC_IDLE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LAYERS*CODE_W-1:0] layer_code,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic                         blank_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         pal_we,
  input  logic [CODE_W-1:0]            pal_addr,
  input  logic [RGB_W-1:0]             pal_data,
  output logic [R_W-1:0]               rouge,
  output logic [G_W-1:0]               vert,
  output logic [B_W-1:0]               bleu,
  output logic                         hsync_out,
  output logic                         vsync_out
);

  logic [CODE_W-1:0] win_code;

  logic [CODE_W-1:0] code_q;
  logic              blank_q;
  logic              hsync_q;
  logic              vsync_q;
  logic              hsync_out_q;
  logic              vsync_out_q;
  rgb_t              pix;

  // Scanning from the lowest-priority layer upwards lets the lowest index overwrite last.
  always_comb begin
    win_code = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_en[k] && (layer_code[k*CODE_W +: CODE_W] != '0)) begin
        win_code = layer_code[k*CODE_W +: CODE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q      <= '0;
      blank_q     <= 1'b1;
      hsync_q     <= SYNC_IDLE;
      vsync_q     <= SYNC_IDLE;
      hsync_out_q <= SYNC_IDLE;
      vsync_out_q <= SYNC_IDLE;
    end else begin
      code_q      <= win_code;
      blank_q     <= blank_in;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      hsync_out_q <= hsync_q;
      vsync_out_q <= vsync_q;
    end
  end

  rgb_palette #(
    .CODE_W (CODE_W)
  ) u_palette (
    .clk     (clk),
    .rst     (rst),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_data),
    .raddr_i (code_q),
    .rmask_i (blank_q),
    .rdata_o (pix)
  );

  assign {rouge, vert, bleu} = pix;
  assign hsync_out           = hsync_out_q;
  assign vsync_out           = vsync_out_q;

endmodule

// File: tb/tb_rgb_layer_mixer.sv
// Self-checking bench for rgb_layer_mixer: directed vector table, hand-written corner
// sequences and a randomized stream checked against a queue-based reference model.
module tb_rgb_layer_mixer;

  localparam int unsigned NL  = 3;
  localparam int unsigned CW  = 5;
  localparam int unsigned NL5 = 5;
  localparam int unsigned CW5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NL*CW-1:0]  layer_code;
  logic [NL-1:0]     layer_en;
  logic              blank_in, hsync_in, vsync_in;
  logic              pal_we;
  logic [CW-1:0]     pal_addr;
  logic [7:0]        pal_data;
  logic [2:0]        rouge, vert;
  logic [1:0]        bleu;
  logic              hsync_out, vsync_out;

  logic [NL5*CW5-1:0] layer_code5;
  logic [NL5-1:0]     layer_en5;
  logic               pal_we5;
  logic [CW5-1:0]     pal_addr5;
  logic [2:0]         rouge5, vert5;
  logic [1:0]         bleu5;
  logic               hsync_out5, vsync_out5;

  rgb_layer_mixer #(
    .NUM_LAYERS (NL),
    .CODE_W     (CW),
    .SYNC_IDLE  (1'b1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .layer_code (layer_code),
    .layer_en   (layer_en),
    .blank_in   (blank_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .rouge      (rouge),
    .vert       (vert),
    .bleu       (bleu),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  rgb_layer_mixer #(
    .NUM_LAYERS (NL5),
    .CODE_W     (CW5),
    .SYNC_IDLE  (1'b1)
  ) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .layer_code (layer_code5),
    .layer_en   (layer_en5),
    .blank_in   (blank_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pal_we     (pal_we5),
    .pal_addr   (pal_addr5),
    .pal_data   (pal_data),
    .rouge      (rouge5),
    .vert       (vert5),
    .bleu       (bleu5),
    .hsync_out  (hsync_out5),
    .vsync_out  (vsync_out5)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  typedef struct {
    logic [4:0] c0, c1, c2;
    logic [2:0] en;
    logic       blank, hs, vs;
    logic [7:0] rgb;
    logic       hso, vso;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] pal_m [32];
  vec_t       vecs [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] exp_rgb, input logic exp_hs,
                         input logic exp_vs);
    chk({name, ".rgb"}, {rouge, vert, bleu}, exp_rgb);
    chk({name, ".sync"}, {6'b0, hsync_out, vsync_out}, {6'b0, exp_hs, exp_vs});
  endtask

  // Colour cube from the palette description: level index -> output intensity.
  function automatic logic [7:0] ref_entry(input int unsigned idx);
    logic [2:0]  rg_map [3];
    logic [1:0]  b_map [3];
    int unsigned d;
    rg_map = '{3'd0, 3'd3, 3'd7};
    b_map  = '{2'd0, 2'd1, 2'd3};
    if (idx == 0) return 8'h00;
    if (idx > 27) return 8'hFF;
    d = idx - 1;
    return {rg_map[d % 3], rg_map[(d / 3) % 3], b_map[d / 9]};
  endfunction

  function automatic logic [CW-1:0] ref_winner(input logic [NL*CW-1:0] codes,
                                               input logic [NL-1:0] en);
    for (int k = 0; k < NL; k++) begin
      if (en[k] && codes[k*CW +: CW] != '0) return codes[k*CW +: CW];
    end
    return '0;
  endfunction

  task automatic reset_model();
    for (int unsigned i = 0; i < 32; i++) pal_m[i] = ref_entry(i);
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pixel, predicts its output and checks the pixel issued one step earlier.
  task automatic step(input logic [NL*CW-1:0] codes, input logic [NL-1:0] en,
                      input logic blank, input logic hs, input logic vs, input logic we,
                      input logic [CW-1:0] addr, input logic [7:0] data, input string name);
    exp_t e;
    layer_code = codes;
    layer_en   = en;
    blank_in   = blank;
    hsync_in   = hs;
    vsync_in   = vs;
    pal_we     = we;
    pal_addr   = addr;
    pal_data   = data;
    if (we && addr != '0) pal_m[addr] = data;
    e.rgb = blank ? 8'h00 : pal_m[ref_winner(codes, en)];
    e.hs  = hs;
    e.vs  = vs;
    exp_q.push_back(e);
    tick();
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk_out(name, e.rgb, e.hs, e.vs);
    end
  endtask

  function automatic logic [4:0] rnd_code();
    int unsigned v;
    v = $urandom_range(0, 47);
    return (v >= 32) ? 5'd0 : v[4:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [9:0]  blank_pat, hs_pat;

    vecs[0] = '{5'd5,  5'd0,  5'd0,  3'b111, 1'b0, 1'b1, 1'b1, {3'd3, 3'd3, 2'd0}, 1'b1, 1'b1};
    vecs[1] = '{5'd0,  5'd27, 5'd1,  3'b111, 1'b0, 1'b0, 1'b1, {3'd7, 3'd7, 2'd3}, 1'b0, 1'b1};
    vecs[2] = '{5'd0,  5'd27, 5'd1,  3'b101, 1'b0, 1'b1, 1'b0, {3'd0, 3'd0, 2'd0}, 1'b1, 1'b0};
    vecs[3] = '{5'd0,  5'd0,  5'd14, 3'b111, 1'b0, 1'b0, 1'b0, {3'd3, 3'd3, 2'd1}, 1'b0, 1'b0};
    vecs[4] = '{5'd28, 5'd3,  5'd0,  3'b111, 1'b0, 1'b1, 1'b1, {3'd7, 3'd7, 2'd3}, 1'b1, 1'b1};
    vecs[5] = '{5'd2,  5'd0,  5'd0,  3'b111, 1'b1, 1'b0, 1'b0, {3'd0, 3'd0, 2'd0}, 1'b0, 1'b0};
    vecs[6] = '{5'd9,  5'd9,  5'd9,  3'b000, 1'b0, 1'b1, 1'b0, {3'd0, 3'd0, 2'd0}, 1'b1, 1'b0};
    vecs[7] = '{5'd10, 5'd20, 5'd0,  3'b110, 1'b0, 1'b1, 1'b1, {3'd3, 3'd0, 2'd3}, 1'b1, 1'b1};
    vecs[8] = '{5'd7,  5'd19, 5'd0,  3'b010, 1'b0, 1'b0, 1'b1, {3'd0, 3'd0, 2'd3}, 1'b0, 1'b1};
    vecs[9] = '{5'd0,  5'd0,  5'd9,  3'b111, 1'b0, 1'b0, 1'b1, {3'd7, 3'd7, 2'd0}, 1'b0, 1'b1};

    // Reset, with a palette write that must be ignored.
    rst         = 1'b1;
    layer_code  = '0;
    layer_en    = '0;
    blank_in    = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    pal_we      = 1'b1;
    pal_addr    = 5'd5;
    pal_data    = 8'h00;
    layer_code5 = '0;
    layer_en5   = '0;
    pal_we5     = 1'b0;
    pal_addr5   = '0;
    tick();
    tick();
    tick();
    chk_out("reset", 8'h00, 1'b1, 1'b1);

    rst        = 1'b0;
    pal_we     = 1'b0;
    layer_code = {5'd0, 5'd0, 5'd5};
    layer_en   = 3'b111;
    vsync_in   = 1'b1;
    tick();
    chk_out("release1", 8'h00, 1'b1, 1'b1);
    tick();
    chk_out("release2", {3'd3, 3'd3, 2'd0}, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      layer_code = {vecs[i].c2, vecs[i].c1, vecs[i].c0};
      layer_en   = vecs[i].en;
      blank_in   = vecs[i].blank;
      hsync_in   = vecs[i].hs;
      vsync_in   = vecs[i].vs;
      tick();
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].hso, vecs[i].vso);
    end

    // Write/lookup collision on entry 3.
    reset_model();
    step({5'd0, 5'd0, 5'd3}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, "coll_pre");
    step({5'd0, 5'd0, 5'd3}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 8'b101_010_01, "coll_wr");
    chk_out("coll_old", {3'd7, 3'd0, 2'd0}, 1'b1, 1'b1);
    step({5'd0, 5'd0, 5'd3}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, "coll_next");
    chk_out("coll_new", {3'd5, 3'd2, 2'd1}, 1'b1, 1'b1);
    step({5'd0, 5'd0, 5'd0}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 8'hFF, "wr0");
    step({5'd0, 5'd0, 5'd0}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, "wr0_a");
    step({5'd0, 5'd0, 5'd0}, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, "wr0_b");
    chk_out("wr0_black", 8'h00, 1'b1, 1'b1);

    // Single-cycle blank and hsync pulses on a lit pixel stream.
    blank_pat = 10'b0001000100;
    hs_pat    = 10'b0100000010;
    for (int i = 0; i < 10; i++) begin
      step({5'd0, 5'd0, 5'd27}, 3'b111, blank_pat[i], hs_pat[i], 1'b1, 1'b0, 5'd0, 8'h00,
           $sformatf("pulse%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      step({rnd_code(), rnd_code(), rnd_code()}, r[2:0], ($urandom_range(0, 7) == 0), r[3],
           r[4], ($urandom_range(0, 3) == 0), r[12:8], r[23:16], "rand");
    end

    // Reset in the middle of active video after overwriting entry 5.
    step({5'd0, 5'd0, 5'd5}, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 8'h00, "mid_wr");
    step({5'd0, 5'd0, 5'd5}, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, "mid_a");
    step({5'd0, 5'd0, 5'd5}, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, "mid_b");
    chk_out("mid_written", 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("midrst", 8'h00, 1'b1, 1'b1);
    rst = 1'b0;
    tick();
    chk_out("midrst_rel1", 8'h00, 1'b1, 1'b1);
    tick();
    chk_out("midrst_rel2", {3'd3, 3'd3, 2'd0}, 1'b0, 1'b0);
    reset_model();

    // Five layers of 3-bit codes.
    blank_in  = 1'b0;
    layer_en5 = 5'b11111;
    for (int unsigned i = 1; i < 8; i++) begin
      layer_code5 = {12'd0, i[2:0]};
      tick();
      tick();
      chk($sformatf("p5_entry%0d", i), {rouge5, vert5, bleu5}, ref_entry(i));
    end
    layer_code5 = {3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    tick();
    tick();
    chk("p5_l4_visible", {rouge5, vert5, bleu5}, ref_entry(6));
    layer_code5 = {3'd6, 3'd2, 3'd0, 3'd0, 3'd0};
    tick();
    tick();
    chk("p5_l3_wins", {rouge5, vert5, bleu5}, ref_entry(2));
    layer_en5 = 5'b10111;
    tick();
    tick();
    chk("p5_l3_disabled", {rouge5, vert5, bleu5}, ref_entry(6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
